// File: rtl/vga_timing_mmio.sv
// VGA timing generator (640x480@60 by default) with a frame-shadowed MMIO result register.
// The result register only updates when the counters wrap to (0,0), so the displayed word never tears.
module vga_timing_mmio #(
    parameter int          H_VISIBLE   = 640,
    parameter int          H_FP        = 16,
    parameter int          H_SYNC      = 96,
    parameter int          H_BP        = 48,
    parameter int          V_VISIBLE   = 480,
    parameter int          V_FP        = 10,
    parameter int          V_SYNC      = 2,
    parameter int          V_BP        = 33,
    parameter logic        SYNC_ACTIVE = 1'b0,
    parameter logic [31:0] RESULT_ADDR = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        video_on,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start,
    output logic [1:0]  result
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       h_wrap;
    logic       v_wrap;
    logic       frame_wrap;
    logic       hs_raw;
    logic       vs_raw;

    logic [1:0] pending;
    logic       upd_pending;
    logic       wr_hit;
    logic [1:0] wr_val;

    always_comb begin
        h_wrap     = (h_cnt == H_LAST);
        v_wrap     = (v_cnt == V_LAST);
        frame_wrap = h_wrap && v_wrap;
        hs_raw     = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
        vs_raw     = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
            hsync <= ~SYNC_ACTIVE;
            vsync <= ~SYNC_ACTIVE;
        end else begin
            h_cnt <= h_wrap ? 10'd0 : h_cnt + 10'd1;
            if (h_wrap) begin
                v_cnt <= v_wrap ? 10'd0 : v_cnt + 10'd1;
            end
            // One cycle of delay keeps sync aligned with the downstream registered RGB.
            hsync <= hs_raw ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync <= vs_raw ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        end
    end

    // CPU port has no handshake: a store is accepted on the edge where cpu_we is high,
    // and cpu_rdata reflects the register state combinationally from cpu_addr.
    always_comb begin
        wr_hit = cpu_we && (cpu_addr == RESULT_ADDR);
        wr_val = (cpu_wdata[1:0] == 2'b11) ? 2'b00 : cpu_wdata[1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending     <= 2'b00;
            upd_pending <= 1'b0;
            result      <= 2'b00;
        end else begin
            if (frame_wrap) begin
                result <= pending;
            end
            // A store on the commit edge wins over the clear so it lands next frame.
            if (wr_hit) begin
                pending     <= wr_val;
                upd_pending <= 1'b1;
            end else if (frame_wrap) begin
                upd_pending <= 1'b0;
            end
        end
    end

    always_comb begin
        pixel_x     = h_cnt;
        pixel_y     = v_cnt;
        video_on    = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        frame_start = (h_cnt == 10'd0) && (v_cnt == 10'd0);
        cpu_rdata   = (cpu_addr == RESULT_ADDR) ? {29'b0, upd_pending, pending} : 32'h0;
    end

endmodule

// File: tb/tb_vga_timing_mmio.sv
// Bench for vga_timing_mmio using a shrunken raster (25x12, 300 cycles per frame).
// Directed stimulus pushes expectations; a negedge monitor pops and compares.
module tb_vga_timing_mmio;

    localparam int HV = 16, HF = 2, HS = 4, HB = 3;
    localparam int VV = 6,  VF = 2, VS = 2, VB = 2;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam logic [31:0] RA = 32'h4000_0000;

    localparam int S_PX = 0, S_PY = 1, S_VON = 2, S_HS = 3, S_VS = 4, S_FS = 5, S_RES = 6, S_RD = 7;

    logic        clk;
    logic        rst;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        video_on;
    logic        hsync;
    logic        vsync;
    logic        frame_start;
    logic [1:0]  result;

    vga_timing_mmio #(
        .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_ACTIVE(1'b0), .RESULT_ADDR(RA)
    ) dut (
        .clk(clk), .rst(rst), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .pixel_x(pixel_x),
        .pixel_y(pixel_y), .video_on(video_on), .hsync(hsync), .vsync(vsync),
        .frame_start(frame_start), .result(result)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int t = 0;

    // scoreboard
    logic [31:0] exp_q[$];
    int          sel_q[$];

    function automatic logic [31:0] pick(int sel);
        case (sel)
            S_PX:    pick = {22'b0, pixel_x};
            S_PY:    pick = {22'b0, pixel_y};
            S_VON:   pick = {31'b0, video_on};
            S_HS:    pick = {31'b0, hsync};
            S_VS:    pick = {31'b0, vsync};
            S_FS:    pick = {31'b0, frame_start};
            S_RES:   pick = {30'b0, result};
            default: pick = cpu_rdata;
        endcase
    endfunction

    function automatic string sname(int sel);
        case (sel)
            S_PX:    sname = "pixel_x";
            S_PY:    sname = "pixel_y";
            S_VON:   sname = "video_on";
            S_HS:    sname = "hsync";
            S_VS:    sname = "vsync";
            S_FS:    sname = "frame_start";
            S_RES:   sname = "result";
            default: sname = "cpu_rdata";
        endcase
    endfunction

    int          hs_run = 0;
    int          vs_run = 0;
    int          fs_gap = 0;
    logic        fs_armed = 1'b0;
    logic        fs_prev = 1'b1;

    // monitor: directed expectations plus sync-width and frame-period measurements
    always @(negedge clk) begin
        int          s;
        logic [31:0] e;
        logic [31:0] a;
        while (sel_q.size() > 0) begin
            s = sel_q.pop_front();
            e = exp_q.pop_front();
            a = pick(s);
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s t=%0d got 0x%0h expected 0x%0h", sname(s), t, a, e);
            end
        end
        if (rst) begin
            hs_run   = 0;
            vs_run   = 0;
            fs_gap   = 0;
            fs_armed = 1'b0;
            fs_prev  = frame_start;
        end else begin
            if (hsync === 1'b0) hs_run++;
            else if (hs_run > 0) begin
                checks++;
                if (hs_run != HS) begin
                    errors++;
                    $display("FAIL hsync_width t=%0d got %0d expected %0d", t, hs_run, HS);
                end
                hs_run = 0;
            end
            if (vsync === 1'b0) vs_run++;
            else if (vs_run > 0) begin
                checks++;
                if (vs_run != VS * HT) begin
                    errors++;
                    $display("FAIL vsync_width t=%0d got %0d expected %0d", t, vs_run, VS * HT);
                end
                vs_run = 0;
            end
            if (frame_start === 1'b1 && fs_prev === 1'b0) begin
                if (fs_armed) begin
                    checks++;
                    if (fs_gap != FT) begin
                        errors++;
                        $display("FAIL frame_period t=%0d got %0d expected %0d", t, fs_gap, FT);
                    end
                end
                fs_armed = 1'b1;
                fs_gap   = 0;
            end
            fs_gap++;
            fs_prev = frame_start;
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic goto(input int x, input int y);
        int n;
        n = ((y * HT + x) - (t % FT) + FT) % FT;
        repeat (n) step();
    endtask

    task automatic next_frame();
        goto(HT - 1, VT - 1);
        step();
    endtask

    task automatic expect_v(input int sel, input logic [31:0] v);
        sel_q.push_back(sel);
        exp_q.push_back(v);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        cpu_we    = 1'b1;
        cpu_addr  = a;
        cpu_wdata = d;
        step();
        cpu_we    = 1'b0;
        cpu_addr  = RA;
    endtask

    task automatic expect_reset_state();
        expect_v(S_PX, 0);
        expect_v(S_PY, 0);
        expect_v(S_VON, 1);
        expect_v(S_FS, 1);
        expect_v(S_HS, 1);
        expect_v(S_VS, 1);
        expect_v(S_RES, 0);
        expect_v(S_RD, 0);
    endtask

    initial begin
        rst       = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = RA;
        cpu_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        t   = 0;
        expect_reset_state();

        // raster basics
        goto(HV - 1, 0); expect_v(S_VON, 1);
        step();          expect_v(S_PX, HV); expect_v(S_VON, 0); expect_v(S_FS, 0);
        goto(HT - 1, 0); expect_v(S_PY, 0);
        step();          expect_v(S_PX, 0); expect_v(S_PY, 1);

        // sync edges, one cycle behind the counters
        goto(HV + HF, 1);          expect_v(S_HS, 1);
        goto(HV + HF + 1, 1);      expect_v(S_HS, 0);
        goto(HV + HF + HS, 1);     expect_v(S_HS, 0);
        goto(HV + HF + HS + 1, 1); expect_v(S_HS, 1);
        goto(0, VV + VF);          expect_v(S_VS, 1);
        goto(1, VV + VF);          expect_v(S_VS, 0);
        goto(0, VV + VF + VS);     expect_v(S_VS, 0);
        goto(1, VV + VF + VS);     expect_v(S_VS, 1);

        // write 1, commit at the frame boundary
        goto(5, 3); wr(RA, 32'h1); expect_v(S_RD, 32'h5); expect_v(S_RES, 0);
        goto(HT - 1, VT - 1);      expect_v(S_RES, 0);
        step();
        expect_v(S_RES, 1); expect_v(S_RD, 32'h1); expect_v(S_FS, 1);
        expect_v(S_PX, 0); expect_v(S_PY, 0);

        // write 2, then write 3 which maps to none
        goto(5, 3); wr(RA, 32'h2); expect_v(S_RD, 32'h6);
        next_frame();              expect_v(S_RES, 2); expect_v(S_RD, 32'h2);
        goto(5, 3); wr(RA, 32'h3); expect_v(S_RD, 32'h4); expect_v(S_RES, 2);
        next_frame();              expect_v(S_RES, 0); expect_v(S_RD, 32'h0);

        // write on the commit edge: old pending commits, new one waits a frame
        goto(5, 3); wr(RA, 32'h1); expect_v(S_RD, 32'h5);
        goto(HT - 1, VT - 1); wr(RA, 32'h2);
        expect_v(S_RES, 1); expect_v(S_RD, 32'h6);
        next_frame();              expect_v(S_RES, 2); expect_v(S_RD, 32'h2);

        // other address ignored and reads back zero
        goto(5, 3);
        cpu_addr = RA + 32'h4;
        expect_v(S_RD, 32'h0);
        wr(RA + 32'h4, 32'h1);     expect_v(S_RD, 32'h2); expect_v(S_RES, 2);
        next_frame();              expect_v(S_RES, 2); expect_v(S_RD, 32'h2);

        // back-to-back stores, last one wins
        goto(5, 3);
        cpu_we = 1'b1; cpu_addr = RA; cpu_wdata = 32'h2; step();
        cpu_wdata = 32'h1; step();
        cpu_we = 1'b0;
        expect_v(S_RD, 32'h5);
        next_frame();              expect_v(S_RES, 1); expect_v(S_RD, 32'h1);

        // mid-frame reset drops the pending store
        goto(5, 3); wr(RA, 32'h2); expect_v(S_RD, 32'h6);
        goto(10, 4);               expect_v(S_PX, 10); expect_v(S_PY, 4);
        rst = 1'b1;
        @(negedge clk);
        step();
        rst = 1'b0;
        t   = 0;
        expect_reset_state();
        next_frame();              expect_v(S_RES, 0); expect_v(S_RD, 32'h0); expect_v(S_FS, 1);

        @(negedge clk);
        #1;
        checks++;
        if (sel_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d left expected 0", sel_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_mmio.md
# vga_timing_mmio

Generates 640x480 @ 60 Hz VGA timing for the text display stage. Counters run on the 25 MHz pixel clock and drive pixel_x, pixel_y, video_on, hsync and vsync. The block also owns the CPU-visible result register at 0x40000000, shadowed so the on-screen word changes only at a frame boundary (no tearing). It feeds the text display directly. hsync/vsync are delayed one cycle so they stay aligned with that stage's registered RGB.

## Interface
Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_VISIBLE, 480, active lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- SYNC_ACTIVE, 1'b0, sync polarity (0 = active-low)
- RESULT_ADDR, 32'h4000_0000, MMIO address of result register

Ports:
- clk  in  1  25 MHz pixel clock
- rst  in  1  synchronous, active-high reset
- cpu_we  in  1  CPU store strobe, one cycle per store
- cpu_addr  in  32  CPU store/load address
- cpu_wdata  in  32  CPU store data
- cpu_rdata  out  32  readback: {29'b0, upd_pending, pending[1:0]} when cpu_addr==RESULT_ADDR, else 0; combinational
- pixel_x  out  10  horizontal counter h_cnt, 0..799
- pixel_y  out  10  vertical counter v_cnt, 0..524
- video_on  out  1  h_cnt<H_VISIBLE && v_cnt<V_VISIBLE
- hsync  out  1  horizontal sync, delayed 1 cycle
- vsync  out  1  vertical sync, delayed 1 cycle
- frame_start  out  1  high while (h_cnt,v_cnt)==(0,0)
- result  out  2  committed result: 00 none, 01 ODD, 10 EVEN

## Operation
- Derived totals: H_TOTAL = 800 and V_TOTAL = 525 with defaults. One frame = 420000 clk cycles.
- h_cnt increments every cycle. At H_TOTAL-1 it wraps to 0 and v_cnt increments.
- v_cnt wraps to 0 when it is at V_TOTAL-1 and h_cnt also wraps.
- Sync windows, decoded from the counters:
  - hs_raw is active for h_cnt in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1], i.e. 656..751.
  - vs_raw is active for v_cnt in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC-1], i.e. 490..491.
- hsync/vsync are registered copies of hs_raw/vs_raw, output at SYNC_ACTIVE polarity.
- pixel_x, pixel_y, video_on and frame_start come straight from the counter registers, with no extra delay.
- MMIO write occurs when cpu_we && cpu_addr==RESULT_ADDR:
  - pending ← cpu_wdata[1:0], with 2'b11 mapped to 2'b00.
  - upd_pending ← 1.
  - Writes to any other address are ignored.
- Commit happens on the edge where the counters wrap from (799,524) to (0,0):
  - result ← pending.
  - upd_pending ← 0.
- Write on the same edge as the commit: result takes the old pending value, pending takes the new value, and upd_pending ends at 1. The new value appears one frame later.
- Back-to-back writes within one frame: the last write wins.
- No handshake; every CPU store completes in one cycle.

## Timing
- Reset (rst high at a clk edge) sets:
  - h_cnt = v_cnt = 0, pending = 00, upd_pending = 0, result = 00.
  - hsync = vsync = !SYNC_ACTIVE (1 with defaults).
  - video_on = 1 and frame_start = 1, because counters are at (0,0).
- rst asserted mid-frame: everything returns to the reset state on the next edge. The pending write is discarded. Counting restarts at (0,0) on the first cycle with rst low.
- Sync latency: 1 cycle relative to the counters. hsync is low from the cycle after h_cnt=656 through the cycle after h_cnt=751, i.e. 96 cycles, then high.
- vsync is low during 2 full lines, offset by 1 cycle from the line-490 start.
- result latency: from a write edge to the commit edge, at most 420000 cycles. It is visible at the first pixel of the next frame.
- Counters never exceed 799/524. There are no illegal states.

## Test plan
- Reset, then release → cycle 0 shows pixel_x=0, pixel_y=0, video_on=1, frame_start=1, hsync=vsync=1, result=00. video_on drops at pixel_x=640. pixel_y increments when pixel_x wraps 799→0.
- Run 2 frames → hsync low exactly 96 cycles per line, starting 1 cycle after pixel_x=656. vsync low exactly 1600 cycles per frame. frame_start pulses every 420000 cycles.
- Write 0x1 to 0x40000000 at (100,200) → cpu_rdata=0x5. result stays 00 until the wrap, then becomes 01 at (0,0) and rdata becomes 0x1. Write 0x2 → result 10 next frame. Write 0x3 → result 00.
- Write 0x2 on the wrap edge while pending=01 → result=01 this frame and 10 the next.
- Write 0x1 to 0x40000004 → pending, rdata and result unchanged.
- Pulse rst at (300,100) with a write pending → all outputs return to reset values and result stays 00 across the next frame boundary.
